// File: rtl/llc_set_table_ctrl_pkg.sv
// llc_set_table_ctrl_pkg: shared constants and types for the LLC set table controller
package llc_set_table_ctrl_pkg;
    localparam int TABLE_SIZE   = 5;
    localparam int PTR_BITS     = 3;
    localparam int LLC_SET_BITS = 8;

    typedef enum logic [1:0] {IDLE, CHECK, STALL, DISPATCH} state_e;

    typedef struct packed {
        logic [LLC_SET_BITS-1:0] set;
        logic [PTR_BITS-1:0]     entry;
    } llc_set_table_ctrl_if_t;
endpackage

// File: rtl/llc_set_table_ctrl.sv
// llc_set_table_ctrl: sequences requests into the LLC set table, tracks occupancy and flush
module llc_set_table_ctrl
    import llc_set_table_ctrl_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [LLC_SET_BITS-1:0] req_set_i,
    output logic                    disp_valid_o,
    input  logic                    disp_ready_i,
    output logic [LLC_SET_BITS-1:0] disp_set_o,
    output logic [PTR_BITS-1:0]     disp_entry_o,
    input  logic                    cpl_valid_i,
    input  logic [PTR_BITS-1:0]     cpl_entry_i,
    input  logic                    flush_req_i,
    output logic                    flush_done_o,
    output logic [LLC_SET_BITS-1:0] tbl_set_next_o,
    output logic                    tbl_check_o,
    output logic                    tbl_add_o,
    output logic                    tbl_remove_o,
    output logic [PTR_BITS-1:0]     tbl_remove_ptr_o,
    output logic                    tbl_clr_o,
    input  logic                    tbl_hit_i,
    input  logic [PTR_BITS-1:0]     tbl_ptr_i,
    output logic [PTR_BITS-1:0]     occ_count_o,
    output logic                    tbl_full_o,
    output logic                    err_spurious_free_o
);
    localparam logic [TABLE_SIZE-1:0] ONE = TABLE_SIZE'(1);

    state_e                  state_q;
    logic [TABLE_SIZE-1:0]   valid_q, valid_d, add_mask, rem_mask;
    logic [PTR_BITS-1:0]     occ_q, occ_d;
    logic [LLC_SET_BITS-1:0] set_q;
    logic                    flush_go, add_go, cpl_hit, ptr_busy, blocked;
    llc_set_table_ctrl_if_t  disp_pkt;

    // Out-of-range entries shift to an all-zero mask, so they read as invalid.
    always_comb begin
        flush_go = state_q == IDLE && flush_req_i;
        add_go   = state_q == DISPATCH && disp_ready_i;
        ptr_busy = |(valid_q & (ONE << tbl_ptr_i));
        cpl_hit  = cpl_valid_i && !flush_go && |(valid_q & (ONE << cpl_entry_i));
        blocked  = tbl_hit_i || ptr_busy;
        add_mask = add_go ? ONE << tbl_ptr_i : '0;
        rem_mask = cpl_hit ? ONE << cpl_entry_i : '0;
        valid_d  = flush_go ? '0 : (valid_q & ~rem_mask) | add_mask;
        occ_d    = flush_go ? '0 : occ_q + PTR_BITS'(add_go) - PTR_BITS'(cpl_hit);
        disp_pkt = '{set: set_q, entry: tbl_ptr_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            valid_q <= '0;
            occ_q   <= '0;
            set_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            case (state_q)
                IDLE: if (!flush_req_i && req_valid_i) begin
                    set_q   <= req_set_i;
                    state_q <= CHECK;
                end
                CHECK:    state_q <= !blocked ? DISPATCH : cpl_valid_i ? CHECK : STALL;
                STALL:    if (cpl_valid_i) state_q <= CHECK;
                DISPATCH: if (disp_ready_i) state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o         = state_q == IDLE && !flush_req_i;
    assign disp_valid_o        = state_q == DISPATCH;
    assign disp_set_o          = disp_pkt.set;
    assign disp_entry_o        = disp_pkt.entry;
    assign flush_done_o        = flush_go;
    assign tbl_clr_o           = flush_go;
    assign tbl_set_next_o      = set_q;
    assign tbl_check_o         = state_q == CHECK;
    assign tbl_add_o           = add_go;
    assign tbl_remove_o        = cpl_hit;
    assign tbl_remove_ptr_o    = cpl_entry_i;
    assign occ_count_o         = occ_q;
    assign tbl_full_o          = occ_q == PTR_BITS'(TABLE_SIZE);
    assign err_spurious_free_o = cpl_valid_i && !flush_go && !cpl_hit;
endmodule

// File: doc/llc_set_table_ctrl.md
Name: llc_set_table_ctrl

Overview:
- Sequencer in front of the LLC set table.
- Accepts incoming requests tagged with an LLC set and checks each one against the table for a same-set conflict.
- Allocates the table entry at the table's round-robin pointer and dispatches the request downstream with its entry id.
- Frees entries on completion and tracks occupancy, since the table itself has no full or overwrite protection. Also sequences table flush.

Parameters:
- TABLE_SIZE, 5, number of set-table entries; must match the set table.
- PTR_BITS, 3, entry-index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  incoming request valid
- req_ready  out  1  controller can latch a request
- req_set  in  LLC_SET_BITS  set of incoming request
- disp_valid  out  1  request cleared for dispatch
- disp_ready  in  1  downstream accepts dispatch
- disp_set  out  LLC_SET_BITS  dispatched set
- disp_entry  out  PTR_BITS  allocated table entry
- cpl_valid  in  1  completion (free) pulse
- cpl_entry  in  PTR_BITS  entry being freed
- flush_req  in  1  request to clear the whole table
- flush_done  out  1  one-cycle pulse when clear is issued
- tbl_set_next  out  LLC_SET_BITS  to table set_next
- tbl_check  out  1  to table check_set_table
- tbl_add  out  1  to table add_set_to_table
- tbl_remove  out  1  to table remove_set_from_table
- tbl_remove_ptr  out  PTR_BITS  to table table_pointer_to_remove
- tbl_clr  out  1  to table clr_set_table
- tbl_hit  in  1  from table is_set_in_table
- tbl_ptr  in  PTR_BITS  from table set_table_pointer
- occ_count  out  PTR_BITS  number of valid entries
- tbl_full  out  1  occ_count == TABLE_SIZE
- err_spurious_free  out  1  one-cycle pulse on completion to an invalid entry

Behaviour:
- Reset: state IDLE, valid bitmap 0, occ_count 0, held set 0. All pulses and valids are 0. req_ready = 1 once out of reset (it is combinational from state).
- State: IDLE. req_ready = !flush_req.
  - flush_req has priority: assert tbl_clr and flush_done for one cycle, clear the bitmap, and set occ_count to 0. Stay in IDLE.
  - Else on req_valid: latch req_set into the held set and go to CHECK.
- State: CHECK. tbl_check = 1; tbl_set_next = held set (driven in all states).
  - Blocked if tbl_hit, or if valid[tbl_ptr] is set (slot not yet freed after an out-of-order completion).
  - Not blocked: go to DISPATCH.
  - Blocked and cpl_valid this cycle: stay in CHECK to re-check against the updated table.
  - Blocked with no completion: go to STALL.
- State: STALL. Go back to CHECK on the cycle after any cpl_valid. Otherwise hold.
- State: DISPATCH. disp_valid = 1, disp_set = held set, disp_entry = tbl_ptr. Outputs stay stable until the handshake.
  - On disp_ready: tbl_add = 1 in the same cycle, valid[tbl_ptr] set, occ_count incremented, go to IDLE.
  - The request is only added to the table once downstream accepts it.
- Completion, any state except flush:
  - If valid[cpl_entry]: tbl_remove = 1 and tbl_remove_ptr = cpl_entry in the same cycle; clear the bit; decrement occ_count.
  - Else: err_spurious_free pulse, no table write.
  - cpl_entry >= TABLE_SIZE is treated as spurious.
- Simultaneous add and free (different entries): both apply in the same cycle and occ_count is unchanged. The same entry cannot collide, because CHECK proved that slot free.
- Flush and completion in the same cycle: the clear dominates, and the completion is dropped without an error.
- Flush is accepted only in IDLE. Requests latched into CHECK, STALL or DISPATCH are not aborted; flush_req waits.
- Exactly one request is in flight in the controller. Back-to-back throughput is one request per 3 cycles (IDLE, CHECK, DISPATCH with disp_ready = 1).
- occ_count never exceeds TABLE_SIZE and never goes below 0; the valid bitmap guarantees this.
- Reset asserted mid-operation returns to the reset values immediately. Any dispatch in progress is lost.

Decomposition:
- Shared package gets:
  - a TABLE_SIZE constant replacing the table's local macro;
  - a PTR_BITS constant;
  - a state enum typedef (IDLE, CHECK, STALL, DISPATCH);
  - an llc_set_table_ctrl_if packet typedef (set, entry).
- The controller is a single module with no sub-module.
- The verification top instantiates the controller together with llc_set_table and connects them by the tbl_* ports.

Test Plan:
- Reset, then req_set = 0x12 with disp_ready = 1 -> tbl_check in cycle 2, disp_valid with disp_entry = 0 in cycle 3, tbl_add in the same cycle, occ_count = 1.
- Dispatch sets 0x01 and 0x02, then request 0x01 -> STALL with disp_valid = 0. Then cpl_entry = 0 -> tbl_remove with ptr 0, re-check, dispatch with disp_entry = 2.
- Fill all 5 entries with distinct sets, then request 0x30 -> blocked with tbl_full = 1. cpl_entry = 3 (not slot 0) -> still stalled. cpl_entry = 0 -> dispatch with disp_entry = 0.
- Blocked in CHECK with cpl_valid in the same cycle -> stays in CHECK and dispatches one cycle later, with no extra STALL cycle.
- cpl_entry = 4 when entry 4 is invalid -> err_spurious_free pulse, tbl_remove = 0, occ_count unchanged. cpl_entry = 6 -> same response.
- Three entries valid, flush_req in IDLE -> tbl_clr and flush_done for 1 cycle, occ_count = 0. A cpl_valid in that same cycle is ignored with no error. Then disp_ready held 0 for 4 cycles -> disp_set and disp_entry stay stable.
